// File: rtl/lbp_pkg.sv
// Shared types and helpers for the LBP histogram block.
package lbp_pkg;

    localparam int unsigned NUM_BINS  = 256;
    localparam int unsigned BIN_W     = 8;
    localparam int unsigned IMG_W_DEF = 128;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_ACCUM = 3'd1,
        S_DRAIN = 3'd2,
        S_DUMP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // True when the {row, col} address lies on the outermost ring of the frame.
    function automatic logic is_edge(input logic [31:0] addr, input int unsigned img_w);
        int unsigned cw;
        logic [31:0] mask;
        logic [31:0] row;
        logic [31:0] col;
        cw   = $clog2(img_w);
        mask = (32'd1 << cw) - 32'd1;
        col  = addr & mask;
        row  = (addr >> cw) & mask;
        return (row == 32'd0) || (col == 32'd0) ||
               (row == img_w - 32'd1) || (col == img_w - 32'd1);
    endfunction

endpackage

// File: rtl/lbp_hist_ram.sv
// 256-entry count RAM: one synchronous read port, one write port, read-old-data on collision.
module lbp_hist_ram
    import lbp_pkg::*;
#(
    parameter int unsigned CNT_W = 15
) (
    input  logic             clk,
    input  logic             we,
    input  logic [BIN_W-1:0] waddr,
    input  logic [CNT_W-1:0] wdata,
    input  logic [BIN_W-1:0] raddr,
    output logic [CNT_W-1:0] rdata
);

    logic [CNT_W-1:0] mem [NUM_BINS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: clear, accumulate one sample per cycle, then stream 256 bins out.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int unsigned IMG_W     = IMG_W_DEF,
    parameter int unsigned CNT_W     = 15,
    parameter bit          SKIP_EDGE = 1'b1,
    localparam int unsigned COORD_W  = $clog2(IMG_W),
    localparam int unsigned ADDR_W   = 2 * COORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic              lbp_valid,
    input  logic [BIN_W-1:0]  lbp_data,
    input  logic              finish,
    output logic              busy,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [BIN_W-1:0]  hist_bin,
    output logic [CNT_W-1:0]  hist_count,
    output logic              hist_done
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    state_t           state;
    logic [BIN_W-1:0] clr_ptr;
    logic [BIN_W:0]   rd_ptr;
    logic             r_vld;
    logic [BIN_W-1:0] r_bin;
    logic             p_vld;
    logic [BIN_W-1:0] p_bin;
    logic             f_vld;
    logic [BIN_W-1:0] f_bin;
    logic [CNT_W-1:0] f_cnt;
    logic [CNT_W-1:0] rdata;

    logic             accept_c;
    logic [CNT_W-1:0] old_c;
    logic [CNT_W-1:0] inc_c;
    logic             load_c;
    logic             advance_c;
    logic             we_c;
    logic [BIN_W-1:0] waddr_c;
    logic [CNT_W-1:0] wdata_c;
    logic [BIN_W-1:0] raddr_c;

    // Stage-1 increment with forwarding of the write issued one cycle earlier.
    always_comb begin
        accept_c  = (state == S_ACCUM) && lbp_valid &&
                    !(SKIP_EDGE && is_edge(32'(lbp_addr), IMG_W));
        old_c     = (f_vld && (f_bin == p_bin)) ? f_cnt : rdata;
        inc_c     = (&old_c) ? old_c : old_c + CNT_W'(1);
        load_c    = !hist_valid || hist_ready;
        advance_c = !r_vld || load_c;
        we_c      = p_vld;
        waddr_c   = p_bin;
        wdata_c   = inc_c;
        raddr_c   = lbp_data;
        if (state == S_CLEAR) begin
            we_c    = 1'b1;
            waddr_c = clr_ptr;
            wdata_c = '0;
        end
        // While stalled, re-read the pending bin so the RAM output stays put.
        if (state == S_DUMP) begin
            raddr_c = advance_c ? rd_ptr[BIN_W-1:0] : r_bin;
        end
    end

    lbp_hist_ram #(.CNT_W(CNT_W)) u_ram (
        .clk   (clk),
        .we    (we_c),
        .waddr (waddr_c),
        .wdata (wdata_c),
        .raddr (raddr_c),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_CLEAR;
            clr_ptr    <= '0;
            busy       <= 1'b1;
            hist_valid <= 1'b0;
            hist_bin   <= '0;
            hist_count <= '0;
            hist_done  <= 1'b0;
            p_vld      <= 1'b0;
            p_bin      <= '0;
            f_vld      <= 1'b0;
            f_bin      <= '0;
            f_cnt      <= '0;
            rd_ptr     <= '0;
            r_vld      <= 1'b0;
            r_bin      <= '0;
        end else begin
            p_vld <= accept_c;
            p_bin <= lbp_data;
            f_vld <= p_vld;
            f_bin <= p_bin;
            f_cnt <= inc_c;
            case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + BIN_W'(1);
                    if (clr_ptr == LAST_BIN) begin
                        state <= S_ACCUM;
                        busy  <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (finish) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state  <= S_DUMP;
                    rd_ptr <= '0;
                    r_vld  <= 1'b0;
                end
                S_DUMP: begin
                    if (load_c) begin
                        hist_valid <= r_vld;
                        hist_bin   <= r_bin;
                        hist_count <= rdata;
                    end
                    if (advance_c) begin
                        r_vld <= !rd_ptr[BIN_W];
                        r_bin <= rd_ptr[BIN_W-1:0];
                        if (!rd_ptr[BIN_W]) begin
                            rd_ptr <= rd_ptr + (BIN_W+1)'(1);
                        end
                    end
                    if (hist_valid && hist_ready && (hist_bin == LAST_BIN)) begin
                        state     <= S_DONE;
                        hist_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    hist_done <= 1'b1;
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: a 15-bit and a 4-bit counter instance share one stimulus stream.
module tb_lbp_hist;
    import lbp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] lbp_addr = '0;
    logic        lbp_valid = 1'b0;
    logic [7:0]  lbp_data = '0;
    logic        finish = 1'b0;
    logic        hist_ready = 1'b0;

    logic        a_busy, a_valid, a_done;
    logic [7:0]  a_bin;
    logic [14:0] a_cnt;
    logic        b_busy, b_valid, b_done;
    logic [7:0]  b_bin;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    lbp_hist #(.IMG_W(128), .CNT_W(15), .SKIP_EDGE(1'b1)) u15 (
        .clk(clk), .reset(reset), .lbp_addr(lbp_addr), .lbp_valid(lbp_valid),
        .lbp_data(lbp_data), .finish(finish), .busy(a_busy), .hist_valid(a_valid),
        .hist_ready(hist_ready), .hist_bin(a_bin), .hist_count(a_cnt), .hist_done(a_done)
    );

    lbp_hist #(.IMG_W(128), .CNT_W(4), .SKIP_EDGE(1'b1)) u4 (
        .clk(clk), .reset(reset), .lbp_addr(lbp_addr), .lbp_valid(lbp_valid),
        .lbp_data(lbp_data), .finish(finish), .busy(b_busy), .hist_valid(b_valid),
        .hist_ready(hist_ready), .hist_bin(b_bin), .hist_count(b_cnt), .hist_done(b_done)
    );

    typedef struct {
        logic       valid;
        logic [7:0] code;
        logic [6:0] row;
        logic [6:0] col;
        logic       cnt;    // expected: 1 if this sample must be counted
    } samp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned exp_cnt [256];
    int unsigned got15 [256];
    int unsigned got4 [256];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, got, want);
        end
    endtask

    function automatic int unsigned sat4(input int unsigned v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic do_reset(input logic fin, input string tag);
        int n;
        reset = 1'b0;
        lbp_valid = 1'b0;
        lbp_data = '0;
        lbp_addr = '0;
        finish = fin;
        hist_ready = 1'b0;
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        foreach (got15[i]) begin got15[i] = 0; got4[i] = 0; end
        @(negedge clk);
        check({tag, " rst_busy"}, 32'(a_busy), 1);
        check({tag, " rst_valid"}, 32'(a_valid | b_valid), 0);
        check({tag, " rst_done"}, 32'(a_done | b_done), 0);
        check({tag, " rst_bin"}, 32'(a_bin), 0);
        check({tag, " rst_count"}, 32'(a_cnt), 0);
        reset = 1'b1;
        n = 0;
        while (a_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, " busy_cycles"}, 32'(n), 256);
        check({tag, " busy4_low"}, 32'(b_busy), 0);
    endtask

    task automatic send_table(input samp_t t[$]);
        for (int i = 0; i < t.size(); i++) begin
            @(negedge clk);
            lbp_valid = t[i].valid;
            lbp_data  = t[i].code;
            lbp_addr  = {t[i].row, t[i].col};
            finish    = (i == t.size() - 1);
            if (t[i].cnt) exp_cnt[t[i].code]++;
        end
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating
    task automatic dump(input int mode, input int stop_after, input string tag);
        int          nxt;
        int          first;
        bit          held;
        bit          r;
        logic [7:0]  hb;
        logic [14:0] hc;
        nxt = 0;
        first = -1;
        held = 1'b0;
        for (int c = 0; c < 3000 && nxt < stop_after; c++) begin
            @(negedge clk);
            lbp_valid = 1'b0;
            if (held) begin
                check({tag, " hold_valid"}, 32'(a_valid), 1);
                check({tag, " hold_bin"}, 32'(a_bin), 32'(hb));
                check({tag, " hold_count"}, 32'(a_cnt), 32'(hc));
            end
            if (a_valid && first < 0) begin
                first = c;
                check({tag, " first_valid_cycle"}, 32'(c), 3);
            end
            r = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            hist_ready = r;
            held = a_valid && !r;
            hb = a_bin;
            hc = a_cnt;
            if (a_valid && r) begin
                check({tag, " bin"}, 32'(a_bin), 32'(nxt));
                check({tag, " count"}, 32'(a_cnt), exp_cnt[nxt]);
                check({tag, " bin4"}, 32'(b_bin), 32'(nxt));
                check({tag, " count4"}, 32'(b_cnt), sat4(exp_cnt[nxt]));
                check({tag, " valid4"}, 32'(b_valid), 1);
                got15[nxt] = 32'(a_cnt);
                got4[nxt]  = 32'(b_cnt);
                nxt++;
            end
        end
        if (nxt < stop_after) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got %0d transfers required %0d", tag, nxt, stop_after);
        end
        if (stop_after == 256) begin
            @(negedge clk);
            check({tag, " end_valid"}, 32'(a_valid | b_valid), 0);
            check({tag, " done15"}, 32'(a_done), 1);
            check({tag, " done4"}, 32'(b_done), 1);
        end
    endtask

    initial begin
        samp_t s2[$];
        samp_t s3[$];
        samp_t s4[$];
        for (int i = 0; i < 5; i++) s2.push_back('{1'b1, 8'hA5, 7'd5, 7'(10 + i), 1'b1});
        s3.push_back('{1'b1, 8'd3, 7'd10, 7'd10, 1'b1});
        s3.push_back('{1'b1, 8'd7, 7'd10, 7'd11, 1'b1});
        s3.push_back('{1'b1, 8'd3, 7'd10, 7'd12, 1'b1});
        s3.push_back('{1'b1, 8'd7, 7'd10, 7'd13, 1'b1});
        s3.push_back('{1'b1, 8'd3, 7'd10, 7'd14, 1'b1});
        s3.push_back('{1'b1, 8'd0, 7'd0, 7'd20, 1'b0});
        s3.push_back('{1'b1, 8'd3, 7'd40, 7'd127, 1'b0});
        s3.push_back('{1'b0, 8'd7, 7'd50, 7'd50, 1'b0});
        for (int i = 0; i < 20; i++) s4.push_back('{1'b1, 8'd9, 7'd64, 7'd64, 1'b1});

        // Idle frame with finish held from reset; samples after DONE are ignored.
        do_reset(1'b1, "idle");
        dump(0, 256, "idle");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lbp_valid = 1'b1;
            lbp_data = 8'd1;
            lbp_addr = {7'd9, 7'd9};
        end
        @(negedge clk);
        lbp_valid = 1'b0;
        check("done_sticky", 32'(a_done), 1);
        check("done_no_valid", 32'(a_valid), 0);

        do_reset(1'b0, "same");
        send_table(s2);
        dump(0, 256, "same");
        check("same bin165", got15[165], 5);
        check("same bin164", got15[164], 0);

        do_reset(1'b0, "alt");
        send_table(s3);
        dump(1, 256, "alt");
        check("alt bin3", got15[3], 3);
        check("alt bin7", got15[7], 2);
        check("alt bin0", got15[0], 0);

        do_reset(1'b0, "sat");
        send_table(s4);
        dump(0, 256, "sat");
        check("sat bin9_cnt15", got15[9], 20);
        check("sat bin9_cnt4", got4[9], 15);

        // Full interior frame, finish with the final sample, then reset mid-DUMP.
        do_reset(1'b0, "frame");
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                @(negedge clk);
                lbp_valid = 1'b1;
                lbp_data = 8'h00;
                lbp_addr = {7'(r), 7'(c)};
                finish = (r == 126) && (c == 126);
            end
        end
        exp_cnt[0] = 15876;
        dump(0, 10, "frame");
        check("frame bin0", got15[0], 15876);
        check("frame bin0_cnt4", got4[0], 15);
        reset = 1'b0;
        #1;
        check("midreset busy", 32'(a_busy & b_busy), 1);
        check("midreset valid", 32'(a_valid | b_valid), 0);
        check("midreset done", 32'(a_done | b_done), 0);
        do_reset(1'b1, "recl");
        dump(0, 256, "recl");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP engine's output stream (lbp_addr/lbp_valid/lbp_data/finish).
- Accumulates a 256-bin histogram of LBP codes over one 128x128 frame.
- After the frame ends, streams the bins out through a valid/ready handshake to the feature-vector stage.
- Counts live in a 256-entry synchronous-read RAM; hazard forwarding supports one sample per cycle.

Parameters:
- IMG_W, 128, image width and height; address is {row, col}, each log2(IMG_W) bits.
- CNT_W, 15, bin counter width; counts saturate at 2^CNT_W-1.
- SKIP_EDGE, 1, 1 = ignore samples whose row or col is 0 or IMG_W-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lbp_addr  in  14  pixel address {row[13:7], col[6:0]} of the incoming sample.
- lbp_valid  in  1  sample qualifier, one sample per cycle max.
- lbp_data  in  8  LBP code = bin index.
- finish  in  1  frame complete; level, held high by upstream.
- busy  out  1  high while clearing; top level gates gray_ready with ~busy.
- hist_valid  out  1  hist_bin/hist_count valid.
- hist_ready  in  1  downstream accepts the current bin.
- hist_bin  out  8  bin index being output.
- hist_count  out  CNT_W  count for hist_bin.
- hist_done  out  1  all 256 bins transferred; sticky until reset.

Behaviour:
- Reset (reset=0, async): state CLEAR, clr_ptr=0, busy=1, hist_valid=0, hist_bin=0, hist_count=0, hist_done=0, pipeline valid flag 0.
- States: CLEAR -> ACCUM -> DRAIN -> DUMP -> DONE.
- CLEAR:
  - Writes 0 to RAM[clr_ptr] each cycle; clr_ptr increments 0..255.
  - After writing 255, go to ACCUM; busy drops the cycle ACCUM is entered (256 cycles after reset release).
  - lbp_valid in CLEAR is ignored.
- ACCUM, stage 0 (sample cycle):
  - A sample is accepted if lbp_valid=1 and it is not filtered by SKIP_EDGE.
  - Issue RAM read at lbp_data; register bin and p_vld.
- ACCUM, stage 1 (next cycle):
  - old = RAM read data, or the forwarded value if the previous stage-1 write targeted the same bin.
  - Write old+1, saturating at 2^CNT_W-1 (no wrap).
  - Back-to-back identical bins must count correctly.
- finish: while in ACCUM, finish=1 moves to DRAIN. A sample valid in the same cycle as finish is still counted.
- DRAIN: one cycle; completes any pending stage-1 write, then goes to DUMP.
- DUMP:
  - Read pointer rd_ptr runs 0..255. RAM read is issued one cycle ahead so hist_valid rises 2 cycles after DUMP entry, holding bin 0.
  - Transfer occurs when hist_valid & hist_ready.
  - While hist_valid=1 and hist_ready=0, hist_bin and hist_count are held stable; no pointer advance, no data loss.
  - With hist_ready held high, one bin per cycle.
  - After bin 255 transfers: hist_valid=0, go to DONE.
- DONE: hist_done=1 and stays; lbp_valid is ignored; only reset leaves DONE.
- Reset mid-operation: immediate return to the reset values above; histogram re-cleared.
- lbp_addr is used only for the edge filter; the RAM index is lbp_data.

Decomposition:
- Package lbp_pkg:
  - state encoding for CLEAR/ACCUM/DRAIN/DUMP/DONE;
  - NUM_BINS=256;
  - IMG_W default;
  - function is_edge(addr, IMG_W).
- Sub-module lbp_hist_ram:
  - 256 x CNT_W, one synchronous read port and one write port;
  - read-during-write to the same address returns old data;
  - forwarding is done in lbp_hist.

Test Plan:
- Reset then idle: busy=1 for exactly 256 cycles after reset release, then 0. With finish=1 and hist_ready=1, the 256 bins all have count 0, bins 0..255 in order, then hist_done=1.
- Same code 8'hA5 on 5 consecutive cycles (non-edge addrs), then finish: bin 165 reports 5; all other bins report 0 (forwarding check).
- Codes 3,7,3,7,3 alternating every cycle, plus one code 0 at row 0 with SKIP_EDGE=1: bin 3 = 3, bin 7 = 2, bin 0 = 0.
- CNT_W=4, 20 samples of code 9: bin 9 saturates at 15, not 4.
- DUMP with hist_ready toggling 1,0,0,1,...: each bin appears exactly once, values held during stalls, 256 transfers total, then hist_done.
- Full 126x126 interior frame of code 8'h00 with finish asserted in the same cycle as the last sample: bin 0 = 15876; reset asserted mid-DUMP restarts CLEAR with busy=1 and hist_valid=0 immediately.
